led_seq_ctrl: RTL and testbench

Memory-mapped sequencer for the 24-bit board LED bank, sitting on the SoC peripheral bus beside the other 0x0xx-decoded I/O blocks. It holds a CPU-written pattern. It drives `led` either statically or as an autonomous blink or rotate animation, timed by an internal prescaler, so the CPU does not have to poll. It also exposes status so software can synchronise to animation steps.

---
 rtl/led_seq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_led_seq_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_seq_ctrl.sv
// Bus-mapped LED sequencer: holds a CPU pattern and plays it statically, blinking or rotating,
// with steps paced by a free-running prescaler so software never has to poll.
module led_seq_ctrl #(
  parameter int TICK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] addr,
  input  logic        wen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [23:0] led
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [11:0] ADDR_DATA   = 12'h060;
  localparam logic [11:0] ADDR_CTRL   = 12'h064;
  localparam logic [11:0] ADDR_PERIOD = 12'h068;
  localparam logic [11:0] ADDR_STATUS = 12'h06C;

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_ROTL   = 2'd2;
  localparam logic [1:0] MODE_ROTR   = 2'd3;

  // The run state doubles as the CTRL.en bit.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [7:0]    period_q, period_d;
  logic [23:0]   pattern_q, pattern_d;
  logic [23:0]   work_q, work_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    tcnt_q, tcnt_d;
  logic [7:0]    step_cnt_q, step_cnt_d;
  logic          phase_q, phase_d;
  logic [23:0]   led_q, led_d;

  logic          wr_data, wr_ctrl, wr_period;
  logic          tick, step;
  logic [7:0]    period_eff;

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:24];

  assign wr_data    = wen && (addr == ADDR_DATA);
  assign wr_ctrl    = wen && (addr == ADDR_CTRL);
  assign wr_period  = wen && (addr == ADDR_PERIOD);
  assign period_eff = (period_q == 8'd0) ? 8'd1 : period_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_STATIC;
      period_q   <= 8'd1;
      pattern_q  <= '0;
      work_q     <= '0;
      presc_q    <= '0;
      tcnt_q     <= '0;
      step_cnt_q <= '0;
      phase_q    <= 1'b1;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      period_q   <= period_d;
      pattern_q  <= pattern_d;
      work_q     <= work_d;
      presc_q    <= presc_d;
      tcnt_q     <= tcnt_d;
      step_cnt_q <= step_cnt_d;
      phase_q    <= phase_d;
      led_q      <= led_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    period_d   = period_q;
    pattern_d  = pattern_q;
    work_d     = work_q;
    presc_d    = presc_q;
    tcnt_d     = tcnt_q;
    step_cnt_d = step_cnt_q;
    phase_d    = phase_q;
    tick       = 1'b0;
    step       = 1'b0;

    case (state_q)
      ST_RUN: begin
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          // Widened so a PERIOD shrunk below tcnt still steps on this tick.
          if (({1'b0, tcnt_q} + 9'd1) >= {1'b0, period_eff}) begin
            step   = 1'b1;
            tcnt_d = 8'd0;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end
        if (step) begin
          step_cnt_d = step_cnt_q + 8'd1;
          case (mode_q)
            MODE_BLINK: phase_d = ~phase_q;
            MODE_ROTL:  work_d  = {work_q[22:0], work_q[23]};
            MODE_ROTR:  work_d  = {work_q[0], work_q[23:1]};
            default:    ;
          endcase
        end
      end
      default: begin
        presc_d    = '0;
        tcnt_d     = 8'd0;
        step_cnt_d = 8'd0;
        phase_d    = 1'b1;
        work_d     = pattern_q;
      end
    endcase

    // Bus writes override any step taken in the same cycle (PERIOD excepted).
    if (wr_data) begin
      pattern_d  = wdata[23:0];
      work_d     = wdata[23:0];
      tcnt_d     = 8'd0;
      phase_d    = 1'b1;
      step_cnt_d = step_cnt_q;
    end
    if (wr_ctrl) begin
      state_d    = state_t'(wdata[2]);
      mode_d     = wdata[1:0];
      presc_d    = '0;
      tcnt_d     = 8'd0;
      step_cnt_d = 8'd0;
      phase_d    = 1'b1;
      work_d     = pattern_q;
    end
    if (wr_period) begin
      period_d = wdata[7:0];
    end
  end

  always_comb begin
    led_d = pattern_q;
    if (state_q == ST_RUN) begin
      case (mode_q)
        MODE_BLINK: led_d = phase_q ? pattern_q : 24'd0;
        MODE_ROTL,
        MODE_ROTR:  led_d = work_q;
        default:    led_d = pattern_q;
      endcase
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      ADDR_DATA:   rdata = {8'd0, pattern_q};
      ADDR_CTRL:   rdata = {29'd0, (state_q == ST_RUN), mode_q};
      ADDR_PERIOD: rdata = {24'd0, period_q};
      ADDR_STATUS: rdata = {22'd0, (state_q == ST_RUN), phase_q, step_cnt_q};
      default:     rdata = 32'd0;
    endcase
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl at TICK_DIV=4: reset, static, blink, rotate, collisions, bus decode.
module tb_led_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] addr = 12'h000;
  logic        wen = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic [23:0] led;

  int pass_cnt = 0;
  int total_cnt = 0;

  led_seq_ctrl #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .wen   (wen),
    .wdata (wdata),
    .rdata (rdata),
    .led   (led)
  );

  always #5 clk = ~clk;

  // Captured at the posedge following the call; returns 1 time unit after that edge.
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wen   = 1'b1;
    wdata = d;
    @(posedge clk);
    #1;
    wen   = 1'b0;
    wdata = 32'd0;
    $display("write addr=%h data=%h", a, d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (led !== 24'h0) $display("FAIL reset_led: got %h expected %h", led, 24'h0); else pass_cnt++;
    addr = 12'h064; #1;
    total_cnt++;
    if (rdata !== 32'h0) $display("FAIL reset_ctrl: got %h expected %h", rdata, 32'h0); else pass_cnt++;
    addr = 12'h068; #1;
    total_cnt++;
    if (rdata !== 32'h1) $display("FAIL reset_period: got %h expected %h", rdata, 32'h1); else pass_cnt++;
    addr = 12'h06C; #1;
    total_cnt++;
    if (rdata !== 32'h100) $display("FAIL reset_status: got %h expected %h", rdata, 32'h100); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_static();
    wr(12'h060, 32'hFFA5A5A5);
    total_cnt++;
    if (led !== 24'h0) $display("FAIL static_latency: got %h expected %h", led, 24'h0); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (led !== 24'hA5A5A5) $display("FAIL static_led: got %h expected %h", led, 24'hA5A5A5); else pass_cnt++;
    addr = 12'h060; #1;
    total_cnt++;
    if (rdata !== 32'h00A5A5A5) $display("FAIL static_rdata: got %h expected %h", rdata, 32'h00A5A5A5); else pass_cnt++;
  endtask

  task automatic test_blink();
    logic [23:0] exp_led;
    logic [31:0] exp_st;
    wr(12'h060, 32'h00FFFFFF);
    wr(12'h068, 32'd2);
    wr(12'h064, 32'h5);
    addr = 12'h06C;
    for (int k = 1; k <= 2048; k++) begin
      @(posedge clk); #1;
      if (k <= 24) begin
        exp_led = (((k - 1) / 8) % 2 == 0) ? 24'hFFFFFF : 24'h0;
        total_cnt++;
        if (led !== exp_led) $display("FAIL blink_led k=%0d: got %h expected %h", k, led, exp_led); else pass_cnt++;
      end
      if (k == 7 || k == 8 || k == 9 || k == 16 || k == 2047 || k == 2048) begin
        exp_st = 32'h200 | ((((k / 8) % 2) == 0) ? 32'h100 : 32'h0) | 32'((k / 8) % 256);
        total_cnt++;
        if (rdata !== exp_st) $display("FAIL blink_status k=%0d: got %h expected %h", k, rdata, exp_st); else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_midrun();
    @(posedge clk); #1;
    total_cnt++;
    if (led !== 24'hFFFFFF) $display("FAIL midrun_led_before: got %h expected %h", led, 24'hFFFFFF); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if (led !== 24'h0) $display("FAIL midrun_led_async: got %h expected %h", led, 24'h0); else pass_cnt++;
    addr = 12'h064; #1;
    total_cnt++;
    if (rdata !== 32'h0) $display("FAIL midrun_ctrl: got %h expected %h", rdata, 32'h0); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    addr = 12'h06C;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (rdata !== 32'h100) $display("FAIL midrun_status_after: got %h expected %h", rdata, 32'h100); else pass_cnt++;
    total_cnt++;
    if (led !== 24'h0) $display("FAIL midrun_led_after: got %h expected %h", led, 24'h0); else pass_cnt++;
  endtask

  task automatic test_rotate();
    logic [23:0] exp_led;
    wr(12'h064, 32'h0);
    wr(12'h060, 32'h1);
    wr(12'h068, 32'd1);
    wr(12'h064, 32'h6);
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if ((k - 1) % 4 == 0) begin
        exp_led = 24'h1 << (((k - 1) / 4) % 24);
        total_cnt++;
        if (led !== exp_led) $display("FAIL rotl_led k=%0d: got %h expected %h", k, led, exp_led); else pass_cnt++;
      end
    end
    wr(12'h064, 32'h7);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 1 || k == 5 || k == 9) begin
        exp_led = (k == 1) ? 24'h000001 : ((k == 5) ? 24'h800000 : 24'h400000);
        total_cnt++;
        if (led !== exp_led) $display("FAIL rotr_led k=%0d: got %h expected %h", k, led, exp_led); else pass_cnt++;
      end
    end
  endtask

  task automatic test_collision();
    wr(12'h064, 32'h0);
    wr(12'h060, 32'h1);
    wr(12'h068, 32'd1);
    wr(12'h064, 32'h6);
    repeat (7) @(posedge clk);
    wr(12'h060, 32'h000F0F0F);
    total_cnt++;
    if (led !== 24'h000002) $display("FAIL coll_led_pre: got %h expected %h", led, 24'h000002); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (led !== 24'h0F0F0F) $display("FAIL coll_led_written: got %h expected %h", led, 24'h0F0F0F); else pass_cnt++;
    addr = 12'h06C; #1;
    total_cnt++;
    if (rdata !== 32'h301) $display("FAIL coll_status: got %h expected %h", rdata, 32'h301); else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (led !== 24'h0F0F0F) $display("FAIL coll_led_hold: got %h expected %h", led, 24'h0F0F0F); else pass_cnt++;
    total_cnt++;
    if (rdata !== 32'h302) $display("FAIL coll_status_step: got %h expected %h", rdata, 32'h302); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (led !== 24'h1E1E1E) $display("FAIL coll_led_next_step: got %h expected %h", led, 24'h1E1E1E); else pass_cnt++;
  endtask

  task automatic test_period_edge();
    wr(12'h064, 32'h0);
    wr(12'h060, 32'h1);
    wr(12'h068, 32'd0);
    wr(12'h064, 32'h6);
    repeat (5) @(posedge clk);
    #1;
    total_cnt++;
    if (led !== 24'h000002) $display("FAIL period0_step1: got %h expected %h", led, 24'h000002); else pass_cnt++;
    repeat (4) @(posedge clk);
    #1;
    total_cnt++;
    if (led !== 24'h000004) $display("FAIL period0_step2: got %h expected %h", led, 24'h000004); else pass_cnt++;
    wr(12'h064, 32'h0);
    wr(12'h068, 32'd5);
    wr(12'h064, 32'h6);
    repeat (8) @(posedge clk);
    wr(12'h068, 32'd2);
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (led !== 24'h000001) $display("FAIL shrink_before: got %h expected %h", led, 24'h000001); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (led !== 24'h000002) $display("FAIL shrink_step: got %h expected %h", led, 24'h000002); else pass_cnt++;
  endtask

  task automatic test_bus();
    wr(12'h064, 32'h0);
    wr(12'h060, 32'h00123456);
    wr(12'h068, 32'h22);
    wr(12'h06C, 32'hFFFFFFFF);
    wr(12'h070, 32'hFFFFFFFF);
    wr(12'h860, 32'hFFFFFFFF);
    addr = 12'h060; #1;
    total_cnt++;
    if (rdata !== 32'h00123456) $display("FAIL bus_data: got %h expected %h", rdata, 32'h00123456); else pass_cnt++;
    addr = 12'h064; #1;
    total_cnt++;
    if (rdata !== 32'h0) $display("FAIL bus_ctrl: got %h expected %h", rdata, 32'h0); else pass_cnt++;
    addr = 12'h068; #1;
    total_cnt++;
    if (rdata !== 32'h22) $display("FAIL bus_period: got %h expected %h", rdata, 32'h22); else pass_cnt++;
    addr = 12'h070; #1;
    total_cnt++;
    if (rdata !== 32'h0) $display("FAIL bus_unmapped: got %h expected %h", rdata, 32'h0); else pass_cnt++;
    addr = 12'h06C; #1;
    total_cnt++;
    if (rdata !== 32'h100) $display("FAIL bus_status: got %h expected %h", rdata, 32'h100); else pass_cnt++;
    total_cnt++;
    if (led !== 24'h123456) $display("FAIL bus_led: got %h expected %h", led, 24'h123456); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_static();
    test_blink();
    test_reset_midrun();
    test_rotate();
    test_collision();
    test_period_edge();
    test_bus();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
